m3_commutation_seq: RTL and testbench

M3_COMMUTATION_SEQ -- requirements
Module: m3_commutation_seq

---
 rtl/m3_commutation_seq.sv | 188 ++++++++++++++++++
 tb/tb_m3_commutation_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_commutation_seq.sv
// Six-step BLDC commutation sequencer driving three irs2007s half-bridge phase codes with high-side PWM.
// Latency: every output is registered and follows the state/counter change that causes it by one clock.
// Backpressure: none; inputs are levels sampled every clock, and outputs are driven continuously.
module m3_commutation_seq #(
    parameter int BRAKE_CYCLES = 1000,
    parameter int MIN_PERIOD   = 2
) (
    input  logic        clkI,
    input  logic        nRstI,
    input  logic        m3runI,
    input  logic        m3forceStopI,
    input  logic        m3invRotateI,
    input  logic [15:0] stepPeriodI,
    input  logic [7:0]  dutyI,
    output logic [1:0]  phaseAo,
    output logic [1:0]  phaseBo,
    output logic [1:0]  phaseCo,
    output logic [2:0]  stepO,
    output logic        stepStrobeO,
    output logic        busyO
);

    // The brake counter only ever holds 0..BRAKE_CYCLES-1.
    localparam int BCW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
    localparam logic [BCW-1:0] BRAKE_LAST = BCW'(BRAKE_CYCLES - 1);
    localparam logic [15:0]    MIN_P      = 16'(MIN_PERIOD);

    localparam logic [1:0] PH_FLOAT = 2'd0;
    localparam logic [1:0] PH_LOW   = 2'd1;
    localparam logic [1:0] PH_HIGH  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [2:0]     stepCnt;
    logic [2:0]     nextStep;
    logic [15:0]    stepTimer;
    logic [15:0]    period;
    logic [15:0]    clampedPeriod;
    logic [7:0]     pwmCnt;
    logic [BCW-1:0] brakeCnt;
    logic           stepPulse;
    logic           stepBoundary;
    logic [1:0]     hiCode;
    logic [1:0]     phA;
    logic [1:0]     phB;
    logic [1:0]     phC;

    // State register.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: force-stop beats everything, brake restarts while it is held.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (m3forceStopI) begin
                    nextState = BRAKE;
                end else if (m3runI && (stepPeriodI != 16'd0)) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (m3forceStopI) begin
                    nextState = BRAKE;
                end else if (!m3runI) begin
                    nextState = IDLE;
                end
            end
            BRAKE: begin
                if (!m3forceStopI && (brakeCnt == BRAKE_LAST)) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Step boundary, clamped period and the next step index in the sampled direction.
    always_comb begin
        stepBoundary  = (state == RUN) && (nextState == RUN) && (stepTimer == period - 16'd1);
        clampedPeriod = (stepPeriodI < MIN_P) ? MIN_P : stepPeriodI;
        if (m3invRotateI) begin
            nextStep = (stepCnt == 3'd0) ? 3'd5 : stepCnt - 3'd1;
        end else begin
            nextStep = (stepCnt == 3'd5) ? 3'd0 : stepCnt + 3'd1;
        end
    end

    // Step timer, PWM counter, period latch and step counter; both counters sit at 0 outside RUN.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            stepTimer <= 16'd0;
            pwmCnt    <= 8'd0;
            period    <= 16'd0;
            stepCnt   <= 3'd0;
            stepPulse <= 1'b0;
        end else begin
            stepPulse <= stepBoundary;
            if (nextState == RUN) begin
                if (state != RUN) begin
                    stepTimer <= 16'd0;
                    pwmCnt    <= 8'd0;
                    period    <= clampedPeriod;
                end else begin
                    pwmCnt <= pwmCnt + 8'd1;
                    if (stepBoundary) begin
                        stepTimer <= 16'd0;
                        period    <= clampedPeriod;
                        stepCnt   <= nextStep;
                    end else begin
                        stepTimer <= stepTimer + 16'd1;
                    end
                end
            end else begin
                stepTimer <= 16'd0;
                pwmCnt    <= 8'd0;
            end
        end
    end

    // Brake duration counter; restarts on entry and for as long as force-stop is held.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            brakeCnt <= '0;
        end else if ((nextState == BRAKE) && ((state != BRAKE) || m3forceStopI)) begin
            brakeCnt <= '0;
        end else if (nextState == BRAKE) begin
            brakeCnt <= brakeCnt + 1'b1;
        end else begin
            brakeCnt <= '0;
        end
    end

    // Phase codes from the commutation table: high side is PWM-gated, low side solid, third floats.
    always_comb begin
        hiCode = (pwmCnt < dutyI) ? PH_HIGH : PH_FLOAT;
        phA    = PH_FLOAT;
        phB    = PH_FLOAT;
        phC    = PH_FLOAT;
        if (state == BRAKE) begin
            phA = PH_LOW;
            phB = PH_LOW;
            phC = PH_LOW;
        end else if (state == RUN) begin
            case (stepCnt)
                3'd0: begin phA = hiCode; phB = PH_LOW; end
                3'd1: begin phA = hiCode; phC = PH_LOW; end
                3'd2: begin phB = hiCode; phC = PH_LOW; end
                3'd3: begin phB = hiCode; phA = PH_LOW; end
                3'd4: begin phC = hiCode; phA = PH_LOW; end
                3'd5: begin phC = hiCode; phB = PH_LOW; end
                default: begin end
            endcase
        end
    end

    // Output registers, one clock behind the internal state.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            phaseAo     <= PH_FLOAT;
            phaseBo     <= PH_FLOAT;
            phaseCo     <= PH_FLOAT;
            stepO       <= 3'd0;
            stepStrobeO <= 1'b0;
            busyO       <= 1'b0;
        end else begin
            phaseAo     <= phA;
            phaseBo     <= phB;
            phaseCo     <= phC;
            stepO       <= stepCnt;
            stepStrobeO <= stepPulse;
            busyO       <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_m3_commutation_seq.sv
// Bench for m3_commutation_seq: expected behaviour is derived in closed form from elapsed clocks.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Each scenario task checks its own results and bumps the shared counters.
module tb_m3_commutation_seq;

    logic        clkI = 1'b0;
    logic        nRstI = 1'b0;
    logic        m3runI = 1'b0;
    logic        m3forceStopI = 1'b0;
    logic        m3invRotateI = 1'b0;
    logic [15:0] stepPeriodI = 16'd0;
    logic [7:0]  dutyI = 8'd0;
    logic [1:0]  phaseAo;
    logic [1:0]  phaseBo;
    logic [1:0]  phaseCo;
    logic [2:0]  stepO;
    logic        stepStrobeO;
    logic        busyO;

    int total = 0;
    int bad   = 0;

    // Commutation table: phase index (A=0, B=1, C=2) of the high and low side per step.
    int hiPh[6] = '{0, 0, 1, 1, 2, 2};
    int loPh[6] = '{1, 2, 2, 0, 0, 1};

    m3_commutation_seq dut (
        .clkI         (clkI),
        .nRstI        (nRstI),
        .m3runI       (m3runI),
        .m3forceStopI (m3forceStopI),
        .m3invRotateI (m3invRotateI),
        .stepPeriodI  (stepPeriodI),
        .dutyI        (dutyI),
        .phaseAo      (phaseAo),
        .phaseBo      (phaseBo),
        .phaseCo      (phaseCo),
        .stepO        (stepO),
        .stepStrobeO  (stepStrobeO),
        .busyO        (busyO)
    );

    always #5 clkI = ~clkI;

    task automatic tick();
        @(posedge clkI);
        #1;
    endtask

    task automatic doReset();
        nRstI        = 1'b0;
        m3runI       = 1'b0;
        m3forceStopI = 1'b0;
        m3invRotateI = 1'b0;
        stepPeriodI  = 16'd0;
        dutyI        = 8'd0;
        repeat (2) tick();
        nRstI = 1'b1;
        tick();
    endtask

    // Starts RUN from IDLE at step 0 and checks every output for ncyc clocks.
    // n counts edges after the one that samples m3runI; the step index at
    // output sample n is floor((n-1)/pe), the PWM count is (n-1) mod 256.
    task automatic runCheck(input int p, input int duty, input bit rev, input int ncyc);
        int pe;
        int k;
        int s;
        int hi;
        int e[3];
        logic expStrobe;
        pe = (p < 2) ? 2 : p;
        stepPeriodI  = 16'(p);
        dutyI        = 8'(duty);
        m3invRotateI = rev;
        m3runI       = 1'b1;
        tick();
        total++;
        if (busyO !== 1'b0 || stepStrobeO !== 1'b0) begin
            bad++;
            $display("FAIL entry_lag: busy=%0b strobe=%0b want 0 0", busyO, stepStrobeO);
        end
        for (int n = 1; n <= ncyc; n++) begin
            tick();
            k = (n - 1) / pe;
            s = rev ? ((6 - (k % 6)) % 6) : (k % 6);
            expStrobe = (n > 1) && (((n - 1) % pe) == 0);
            hi = (((n - 1) % 256) < duty) ? 2 : 0;
            e[0] = 0; e[1] = 0; e[2] = 0;
            e[hiPh[s]] = hi;
            e[loPh[s]] = 1;
            total++;
            if (busyO !== 1'b1) begin
                bad++;
                $display("FAIL run_busy n=%0d: got %0b want 1", n, busyO);
            end
            total++;
            if (stepO !== 3'(s)) begin
                bad++;
                $display("FAIL run_step n=%0d p=%0d rev=%0b: got %0d want %0d", n, p, rev, stepO, s);
            end
            total++;
            if (stepStrobeO !== expStrobe) begin
                bad++;
                $display("FAIL run_strobe n=%0d p=%0d: got %0b want %0b", n, p, stepStrobeO, expStrobe);
            end
            total++;
            if ({phaseAo, phaseBo, phaseCo} !== {2'(e[0]), 2'(e[1]), 2'(e[2])}) begin
                bad++;
                $display("FAIL run_phase n=%0d step=%0d duty=%0d: got A%0d B%0d C%0d want A%0d B%0d C%0d",
                         n, s, duty, phaseAo, phaseBo, phaseCo, e[0], e[1], e[2]);
            end
        end
    endtask

    task automatic test_reset();
        nRstI = 1'b0;
        #2;
        total++;
        if ({phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO});
        end
        doReset();
        tick();
        total++;
        if ({phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO} !== 11'd0) begin
            bad++;
            $display("FAIL idle_outputs: got %h want 0", {phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO});
        end
        // Reset in the middle of a step clears everything without waiting for an edge.
        runCheck(10, 128, 1'b0, 25);
        #3;
        nRstI = 1'b0;
        #1;
        total++;
        if ({phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO} !== 11'd0) begin
            bad++;
            $display("FAIL reset_midstep: got %h want 0", {phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO});
        end
        doReset();
    endtask

    task automatic test_forward();
        doReset();
        runCheck(10, 128, 1'b0, 70);
    endtask

    task automatic test_reverse_midstep();
        int want[4] = '{2, 1, 0, 5};
        int got;
        doReset();
        runCheck(10, 128, 1'b0, 35);
        m3invRotateI = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 4; c++) begin
            tick();
            if (stepStrobeO === 1'b1) begin
                total++;
                if (stepO !== 3'(want[got])) begin
                    bad++;
                    $display("FAIL reverse_step idx=%0d: got %0d want %0d", got, stepO, want[got]);
                end
                got++;
            end
        end
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL reverse_timeout: strobes seen %0d want 4", got);
        end
    endtask

    task automatic test_brake();
        int ones;
        int held;
        doReset();
        runCheck(10, 128, 1'b0, 47);
        held = (47 / 10) % 6;
        m3forceStopI = 1'b1;
        m3runI       = 1'b0;
        tick();
        m3forceStopI = 1'b0;
        ones = 0;
        for (int i = 1; i <= 1010; i++) begin
            tick();
            if (phaseAo === 2'd1 && phaseBo === 2'd1 && phaseCo === 2'd1 && busyO === 1'b1) begin
                ones++;
            end
        end
        total++;
        if (ones != 1000) begin
            bad++;
            $display("FAIL brake_length: got %0d want 1000", ones);
        end
        total++;
        if ({phaseAo, phaseBo, phaseCo, busyO} !== 7'd0) begin
            bad++;
            $display("FAIL brake_exit: got %h want 0", {phaseAo, phaseBo, phaseCo, busyO});
        end
        total++;
        if (stepO !== 3'(held)) begin
            bad++;
            $display("FAIL brake_step_held: got %0d want %0d", stepO, held);
        end
    endtask

    task automatic test_period_zero();
        int strobes;
        int lastT;
        doReset();
        stepPeriodI = 16'd0;
        m3runI      = 1'b1;
        repeat (20) tick();
        total++;
        if ({phaseAo, phaseBo, phaseCo, busyO} !== 7'd0) begin
            bad++;
            $display("FAIL period0_no_run: got %h want 0", {phaseAo, phaseBo, phaseCo, busyO});
        end
        m3runI = 1'b0;
        doReset();
        runCheck(1, 77, 1'b0, 30);
        // Period dropping to 0 mid-run: commutation continues at the minimum period.
        doReset();
        runCheck(7, 100, 1'b0, 20);
        stepPeriodI = 16'd0;
        strobes = 0;
        lastT   = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (stepStrobeO === 1'b1) begin
                if (lastT >= 0) begin
                    total++;
                    if (t - lastT != 2) begin
                        bad++;
                        $display("FAIL clamp_gap t=%0d: got %0d want 2", t, t - lastT);
                    end
                end
                lastT = t;
                strobes++;
            end
        end
        total++;
        if (strobes != 20 || busyO !== 1'b1) begin
            bad++;
            $display("FAIL clamp_strobes: got %0d busy=%0b want 20 busy=1", strobes, busyO);
        end
    endtask

    task automatic test_duty(input int duty);
        int highs;
        int threes;
        doReset();
        stepPeriodI = 16'd10;
        dutyI       = 8'(duty);
        m3runI      = 1'b1;
        repeat (2) tick();
        highs  = 0;
        threes = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (phaseAo === 2'd2 || phaseBo === 2'd2 || phaseCo === 2'd2) highs++;
            if (phaseAo === 2'd3 || phaseBo === 2'd3 || phaseCo === 2'd3) threes++;
        end
        total++;
        if (highs != 2 * duty) begin
            bad++;
            $display("FAIL duty_count duty=%0d: got %0d want %0d", duty, highs, 2 * duty);
        end
        total++;
        if (threes != 0) begin
            bad++;
            $display("FAIL code3_seen duty=%0d: got %0d want 0", duty, threes);
        end
    endtask

    task automatic test_reset_midbrake();
        doReset();
        runCheck(10, 128, 1'b0, 30);
        m3forceStopI = 1'b1;
        m3runI       = 1'b0;
        tick();
        m3forceStopI = 1'b0;
        repeat (100) tick();
        total++;
        if ({phaseAo, phaseBo, phaseCo, busyO} !== {2'd1, 2'd1, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL midbrake_state: got %h want %h", {phaseAo, phaseBo, phaseCo, busyO}, {2'd1, 2'd1, 2'd1, 1'b1});
        end
        #3;
        nRstI = 1'b0;
        #1;
        total++;
        if ({phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO} !== 11'd0) begin
            bad++;
            $display("FAIL reset_midbrake: got %h want 0", {phaseAo, phaseBo, phaseCo, stepO, stepStrobeO, busyO});
        end
        tick();
        nRstI = 1'b1;
        tick();
        runCheck(10, 128, 1'b0, 70);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            doReset();
            runCheck(int'($urandom_range(1, 12)), int'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), int'($urandom_range(60, 150)));
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_midstep();
        test_brake();
        test_period_zero();
        test_duty(0);
        test_duty(255);
        test_duty(int'($urandom_range(1, 254)));
        test_reset_midbrake();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
